motor_hbridge_sequencer: RTL and testbench
==========================================

MOTOR_HBRIDGE_SEQUENCER -- requirements
Module: motor_hbridge_sequencer

Interface
REQ-001 Parameter DEAD_CYC, default 4: number of all-off cycles inserted before any new drive direction.
REQ-002 Parameter RAMP_DIV, default 16: cycles per +1 step of the soft-start duty ramp.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port ena  in  1  block enable; low forces idle.
REQ-006 Port cmd  in  2  drive command: 00 standby, 01 forward, 10 right, 11 left.
REQ-007 Port cmd_valid  in  1  cmd and duty are valid this cycle.
REQ-008 Port duty  in  8  target PWM duty, 0..255.
REQ-009 Port cmd_ready  out  1  block accepts a command this cycle.
REQ-010 Port motor_out  out  4  {A_fwd, A_rev, B_fwd, B_rev} H-bridge gate enables.
REQ-011 Port busy  out  1  high in DEAD or RAMP.
REQ-012 Port state_o  out  2  current state: 00 IDLE, 01 DEAD, 10 RAMP, 11 RUN.

Function
REQ-013 The block SHALL implement the states IDLE, DEAD, RAMP and RUN, with registers cur_cmd[1:0], tgt_duty[7:0], cur_duty[7:0], dead_cnt, ramp_cnt and pwm_cnt[7:0].
REQ-014 A command is accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal ena AND (state != DEAD).
REQ-015 pwm_cnt SHALL run freely 0..255 and wrap to 0; pwm_on SHALL equal (pwm_cnt < cur_duty), so duty 255 gives 255/256 on-time and duty 0 gives always off.
REQ-016 Direction map, gated by pwm_on, valid in RAMP and RUN only: forward = A_fwd,B_fwd; right = A_fwd,B_rev; left = A_rev,B_fwd.
REQ-017 motor_out SHALL be 0000 in IDLE and DEAD; A_fwd&A_rev and B_fwd&B_rev SHALL never be high in the same cycle.
REQ-018 Accepting standby in any state SHALL go to IDLE next cycle with cur_duty=0.
REQ-019 IDLE plus an accepted non-standby cmd SHALL latch cur_cmd and tgt_duty=duty, set cur_duty=0, and go to DEAD.
REQ-020 DEAD SHALL last exactly DEAD_CYC cycles and then go to RAMP.
REQ-021 In RAMP, cur_duty SHALL increase by 1 every RAMP_DIV cycles while cur_duty<tgt_duty.
REQ-022 RAMP SHALL go to RUN in the cycle after cur_duty==tgt_duty; with tgt_duty=0 it goes to RUN after one RAMP cycle.
REQ-023 In RAMP or RUN, an accepted cmd different from cur_cmd (a polarity reversal) SHALL set cur_duty=0, latch the new cmd and duty, and go to DEAD.
REQ-024 In RAMP or RUN, an accepted cmd equal to cur_cmd SHALL update tgt_duty with these effects:
  - duty<=cur_duty: cur_duty=duty next cycle, state RUN.
  - duty>cur_duty: state RAMP, cur_duty unchanged, ramp_cnt cleared.
REQ-025 ena low SHALL force the state to IDLE and cur_duty=0 synchronously and SHALL override any command in the same cycle.
REQ-026 When ramp_cnt reaches its increment in the same cycle as a command is accepted, the command SHALL take priority.

Reset
REQ-027 While rst_n is low, the block SHALL hold:
  - state IDLE; motor_out=0000; busy=0.
  - cur_cmd=00; tgt_duty, cur_duty, pwm_cnt, dead_cnt and ramp_cnt all 0.
REQ-028 Reset asserted mid-DEAD, mid-RAMP or in RUN SHALL clear motor_out within the same cycle; after release the block SHALL be in IDLE with cmd_ready=ena.

Verification
REQ-029 Bench scenario, start from idle:
  - Stimulus: ena=1, accept cmd=01, duty=8.
  - Response: state DEAD for 4 cycles with motor_out=0000; then RAMP, with cur_duty reaching 8 after 128 cycles; then RUN.
  - In RUN, A_fwd=B_fwd=1 for pwm_cnt 0..7 and 0 for pwm_cnt 8..255.
REQ-030 Bench scenario, reversal: in RUN with cmd 01/duty 200, accept cmd=11 -> the next cycle shows motor_out=0000 and DEAD; A_rev and A_fwd are never high together across the transition.
REQ-031 Bench scenario, same-command duty decrease: in RUN with cmd 10/duty 100, accept cmd=10/duty 20 -> no DEAD; cur_duty=20 next cycle.
REQ-032 Bench scenario, standby and enable:
  - Accepting standby mid-RAMP -> IDLE next cycle, motor_out=0000.
  - Dropping ena while cmd_valid is high -> IDLE, and cmd_ready=0.
REQ-033 Bench scenario, DEAD back-pressure: during DEAD, hold cmd_valid with cmd=10 -> cmd_ready=0 for all 4 cycles, and the command is accepted in the first RAMP cycle.
REQ-034 Bench scenario, async reset: assert rst_n=0 asynchronously in RUN with duty 255 -> motor_out=0000 before the next clock edge, all registers 0.

Source files
------------

// File: rtl/motor_hbridge_sequencer_if.sv
// Command handshake between a drive controller and the H-bridge sequencer.
// The master supplies direction and target duty, and the slave answers with cmd_ready.
interface motor_hbridge_sequencer_if;
   logic [1:0] cmd;
   logic       cmd_valid;
   logic [7:0] duty;
   logic       cmd_ready;

   modport master (output cmd, output cmd_valid, output duty, input cmd_ready);
   modport slave  (input cmd, input cmd_valid, input duty, output cmd_ready);
endinterface

// File: rtl/motor_hbridge_sequencer.sv
// Dual H-bridge sequencer with dead time before each new direction, soft-start duty ramp and PWM gating.
// Gate enables are decoded from registered state only, so an asynchronous reset blanks them at once.
module motor_hbridge_sequencer #(
   parameter int DEAD_CYC = 4,
   parameter int RAMP_DIV = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   motor_hbridge_sequencer_if.slave   cmd_if,
   output logic [3:0]                 motor_out,
   output logic                       busy,
   output logic [1:0]                 state_o
);

   localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam int RCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_CYC - 1);
   localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_DIV - 1);
   localparam logic [1:0]     CMD_STANDBY = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DEAD = 2'b01,
      RAMP = 2'b10,
      RUN  = 2'b11
   } state_t;

   state_t         state;
   logic [1:0]     cur_cmd;
   logic [7:0]     tgt_duty;
   logic [7:0]     cur_duty;
   logic [DCW-1:0] dead_cnt;
   logic [RCW-1:0] ramp_cnt;
   logic [7:0]     pwm_cnt;
   logic           cmd_ready;
   logic           accept;
   logic           pwm_on;

   // Opposing gates of one leg are never enabled together: each code sets at most one bit per leg.
   function automatic logic [3:0] drive_map(input logic [1:0] dir);
      logic [3:0] gates;
      case (dir)
         2'b01:   gates = 4'b1010;
         2'b10:   gates = 4'b1001;
         2'b11:   gates = 4'b0110;
         default: gates = 4'b0000;
      endcase
      return gates;
   endfunction

   assign cmd_ready        = ena && (state != DEAD);
   assign cmd_if.cmd_ready = cmd_ready;
   assign accept           = cmd_if.cmd_valid && cmd_ready;
   assign pwm_on           = (pwm_cnt < cur_duty);
   assign motor_out        = (((state == RAMP) || (state == RUN)) && pwm_on) ? drive_map(cur_cmd) : 4'b0000;
   assign busy             = (state == DEAD) || (state == RAMP);
   assign state_o          = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_cmd  <= 2'b00;
         tgt_duty <= 8'd0;
         cur_duty <= 8'd0;
         dead_cnt <= '0;
         ramp_cnt <= '0;
         pwm_cnt  <= 8'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (!ena) begin
            state    <= IDLE;
            cur_duty <= 8'd0;
            dead_cnt <= '0;
            ramp_cnt <= '0;
         end else if (accept && (cmd_if.cmd == CMD_STANDBY)) begin
            state    <= IDLE;
            cur_cmd  <= CMD_STANDBY;
            tgt_duty <= 8'd0;
            cur_duty <= 8'd0;
            dead_cnt <= '0;
            ramp_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     cur_cmd  <= cmd_if.cmd;
                     tgt_duty <= cmd_if.duty;
                     cur_duty <= 8'd0;
                     dead_cnt <= '0;
                     state    <= DEAD;
                  end
               end
               DEAD: begin
                  if (dead_cnt == DEAD_LAST) begin
                     dead_cnt <= '0;
                     ramp_cnt <= '0;
                     state    <= RAMP;
                  end else begin
                     dead_cnt <= dead_cnt + 1'b1;
                  end
               end
               RAMP, RUN: begin
                  // An accepted command pre-empts a ramp step due in the same cycle.
                  if (accept && (cmd_if.cmd != cur_cmd)) begin
                     cur_cmd  <= cmd_if.cmd;
                     tgt_duty <= cmd_if.duty;
                     cur_duty <= 8'd0;
                     dead_cnt <= '0;
                     state    <= DEAD;
                  end else if (accept) begin
                     tgt_duty <= cmd_if.duty;
                     if (cmd_if.duty <= cur_duty) begin
                        cur_duty <= cmd_if.duty;
                        state    <= RUN;
                     end else begin
                        ramp_cnt <= '0;
                        state    <= RAMP;
                     end
                  end else if (state == RAMP) begin
                     if (cur_duty >= tgt_duty) begin
                        state <= RUN;
                     end else if (ramp_cnt == RAMP_LAST) begin
                        cur_duty <= cur_duty + 8'd1;
                        ramp_cnt <= '0;
                     end else begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_motor_hbridge_sequencer.sv
// Randomised and directed bench for motor_hbridge_sequencer with a timestamp-based reference model.
// Expected outputs are queued per cycle and compared on the falling edge by a separate monitor.
module tb_motor_hbridge_sequencer;
   localparam int DEAD_CYC = 4;
   localparam int RAMP_DIV = 16;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [3:0] motor_out;
   logic       busy;
   logic [1:0] state_o;

   motor_hbridge_sequencer_if bus ();

   motor_hbridge_sequencer #(.DEAD_CYC(DEAD_CYC), .RAMP_DIV(RAMP_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .cmd_if    (bus),
      .motor_out (motor_out),
      .busy      (busy),
      .state_o   (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] st;
      logic [3:0] mo;
      logic       bsy;
      logic       rdy;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: a drive is described by its ramp start cycle, base duty and target; DEAD precedes r0.
   bit m_idle = 1'b1;
   int m_cmd  = 0;
   int m_tgt  = 0;
   int m_b    = 0;
   int m_r0   = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", name, $time, cyc, act, req);
      end
   endtask

   function automatic logic [3:0] dir_gates(input int c);
      case (c)
         1:       return 4'b1010;
         2:       return 4'b1001;
         3:       return 4'b0110;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic m_eval(input int c, output int st, output int d);
      if (m_idle) begin
         st = 0; d = 0;
      end else if (c < m_r0) begin
         st = 1; d = 0;
      end else begin
         d = m_b + (c - m_r0) / RAMP_DIV;
         if (d > m_tgt) d = m_tgt;
         st = (c > m_r0 + (m_tgt - m_b) * RAMP_DIV) ? 3 : 2;
      end
   endtask

   // Applies inputs for one cycle, queues the expected response, then advances the model.
   task automatic drive(input bit e, input bit v, input logic [1:0] c_in, input int du);
      int   st, d;
      bit   rdy;
      exp_t x;
      ena           = e;
      bus.cmd_valid = v;
      bus.cmd       = c_in;
      bus.duty      = du[7:0];
      m_eval(cyc, st, d);
      rdy   = e && (st != 1);
      x.st  = st[1:0];
      x.bsy = (st == 1) || (st == 2);
      x.rdy = rdy;
      x.mo  = ((st >= 2) && ((cyc % 256) < d)) ? dir_gates(m_cmd) : 4'b0000;
      q.push_back(x);
      if (!e) begin
         m_idle = 1'b1;
      end else if (v && rdy) begin
         if (c_in == 2'b00) begin
            m_idle = 1'b1;
         end else if (st == 0 || int'(c_in) != m_cmd) begin
            m_idle = 1'b0; m_cmd = int'(c_in); m_tgt = du; m_b = 0; m_r0 = cyc + 1 + DEAD_CYC;
         end else if (du <= d) begin
            m_tgt = du; m_b = du; m_r0 = cyc;
         end else begin
            m_tgt = du; m_b = d; m_r0 = cyc + 1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, 2'b00, 0);
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_motor_out_now", {4'b0, motor_out}, 8'd0);
      chk("rst_state_now", {6'b0, state_o}, 8'd0);
      chk("rst_busy_now", {7'b0, busy}, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state_hold", {6'b0, state_o}, 8'd0);
      chk("rst_motor_out_hold", {4'b0, motor_out}, 8'd0);
      rst_n  = 1'b1;
      m_idle = 1'b1;
      cyc    = 0;
      #1;
      chk("rst_cmd_ready_release", {7'b0, bus.cmd_ready}, {7'b0, ena});
   endtask

   always @(negedge clk) begin : monitor
      exp_t x;
      if (rst_n) begin
         chk("a_leg_exclusive", {7'b0, motor_out[3] & motor_out[2]}, 8'd0);
         chk("b_leg_exclusive", {7'b0, motor_out[1] & motor_out[0]}, 8'd0);
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("state_o", {6'b0, state_o}, {6'b0, x.st});
            chk("motor_out", {4'b0, motor_out}, {4'b0, x.mo});
            chk("busy", {7'b0, busy}, {7'b0, x.bsy});
            chk("cmd_ready", {7'b0, bus.cmd_ready}, {7'b0, x.rdy});
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst_n         = 1'b0;
      ena           = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
      bus.duty      = 8'd0;
      #1;
      chk("reset_state", {6'b0, state_o}, 8'd0);
      chk("reset_motor_out", {4'b0, motor_out}, 8'd0);
      chk("reset_busy", {7'b0, busy}, 8'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;

      // Soft start from idle, then a full PWM period in RUN.
      drive(1'b1, 1'b1, 2'b01, 8);
      idle(DEAD_CYC + 8 * RAMP_DIV + 1 + 300);

      // Reversal out of RUN.
      drive(1'b1, 1'b1, 2'b01, 200);
      idle(DEAD_CYC + 200 * RAMP_DIV + 20);
      drive(1'b1, 1'b1, 2'b11, 50);
      idle(DEAD_CYC + 50 * RAMP_DIV + 20);

      // Same-command duty decrease in RUN.
      drive(1'b1, 1'b1, 2'b00, 0);
      drive(1'b1, 1'b1, 2'b10, 100);
      idle(DEAD_CYC + 100 * RAMP_DIV + 10);
      drive(1'b1, 1'b1, 2'b10, 20);
      idle(300);

      // Standby mid-ramp, then enable dropped while a command is offered.
      drive(1'b1, 1'b1, 2'b00, 0);
      drive(1'b1, 1'b1, 2'b01, 50);
      idle(DEAD_CYC + 40);
      drive(1'b1, 1'b1, 2'b00, 0);
      idle(5);
      drive(1'b1, 1'b1, 2'b01, 10);
      idle(DEAD_CYC + 20);
      repeat (3) drive(1'b0, 1'b1, 2'b10, 30);
      idle(3);

      // Command held through DEAD, taken in the first RAMP cycle.
      drive(1'b1, 1'b1, 2'b01, 5);
      repeat (DEAD_CYC + 1) drive(1'b1, 1'b1, 2'b10, 30);
      idle(DEAD_CYC + 30 * RAMP_DIV + 10);

      // Zero target and a same-command increase from RUN.
      drive(1'b1, 1'b1, 2'b11, 0);
      idle(DEAD_CYC + 5);
      drive(1'b1, 1'b1, 2'b11, 3);
      idle(3 * RAMP_DIV + 260);

      // Full duty, then asynchronous reset in RUN.
      drive(1'b1, 1'b1, 2'b00, 0);
      drive(1'b1, 1'b1, 2'b01, 255);
      idle(DEAD_CYC + 255 * RAMP_DIV + 40);
      async_reset();
      idle(5);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         drive($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 2,
               2'($urandom_range(0, 3)), int'($urandom_range(0, 30)));
      end
      idle(20);

      @(negedge clk);
      #1;
      chk("queue_drained", 8'(q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
